// File: rtl/gol_pkg.sv
// Shared Game of Life definitions: grid geometry, loader FSM states and grid index helper.
package gol_pkg;

  localparam int GOL_ROWS = 16;
  localparam int GOL_COLS = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } loader_state_e;

  function automatic int grid_idx(input int r, input int c);
    return GOL_COLS * r + c;
  endfunction

endpackage

// File: rtl/gol_pattern_loader.sv
// Assembles seed rows from a valid/ready stream into a full frame and pulses load to the GoL core.
// Optional build macro GOL_LOADER_TIMEOUT_EN discards frames that stall for TIMEOUT_CYC cycles.
module gol_pattern_loader
  import gol_pkg::*;
#(
  parameter int ROWS  = GOL_ROWS,
  parameter int COLS  = GOL_COLS,
  parameter int CNT_W = 8
`ifdef GOL_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [COLS-1:0]      row_data,
  input  logic                 row_last,
  output logic                 load,
  output logic [ROWS*COLS-1:0] data,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 busy
);

  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  loader_state_e          state_reg;
  logic [IDX_W-1:0]       row_idx_reg;
  logic [ROWS*COLS-1:0]   staging_reg;
  logic [ROWS*COLS-1:0]   staging_next;
  logic [IDX_W-1:0]       beat_idx;
  logic                   beat;
  logic                   at_last;
  logic                   timeout;

  assign beat     = row_valid && row_ready;
  // A frame always begins at row 0 from IDLE, whatever row_idx last held.
  assign beat_idx = (state_reg == ST_FILL) ? row_idx_reg : '0;
  assign at_last  = (beat_idx == LAST_IDX);

  always_comb begin
    staging_next = staging_reg;
    staging_next[COLS*beat_idx +: COLS] = row_data;
  end

`ifdef GOL_LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt_reg;

  assign timeout = (state_reg == ST_FILL) && !beat &&
                   (idle_cnt_reg == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else if (state_reg != ST_FILL || beat || timeout) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      row_idx_reg <= '0;
      staging_reg <= '0;
      row_ready   <= 1'b0;
      load        <= 1'b0;
      data        <= '0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      busy        <= 1'b0;
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_FILL: begin
          row_ready <= 1'b1;
          if (beat && (row_last != at_last)) begin
            // Short or long frame: the beat is consumed and the frame dropped.
            frame_err   <= 1'b1;
            staging_reg <= '0;
            row_idx_reg <= '0;
            state_reg   <= ST_IDLE;
            busy        <= 1'b0;
          end else if (beat && row_last) begin
            data        <= staging_next;
            load        <= 1'b1;
            frame_cnt   <= frame_cnt + 1'b1;
            row_ready   <= 1'b0;
            staging_reg <= '0;
            row_idx_reg <= '0;
            state_reg   <= ST_COMMIT;
            busy        <= 1'b1;
          end else if (beat) begin
            staging_reg <= staging_next;
            row_idx_reg <= beat_idx + 1'b1;
            state_reg   <= ST_FILL;
            busy        <= 1'b1;
          end else if (timeout) begin
            frame_err   <= 1'b1;
            staging_reg <= '0;
            row_idx_reg <= '0;
            state_reg   <= ST_IDLE;
            busy        <= 1'b0;
          end
        end
        ST_COMMIT: begin
          row_ready <= 1'b1;
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
